shadow_err_alert: RTL and testbench
===================================

SHADOW_ERR_ALERT -- requirements
Module: shadow_err_alert

Interface
REQ-001 SHALL have parameter NumRegs, default 4: number of shadowed registers monitored (1..32).
REQ-002 SHALL have parameter AckTimeout, default 255: cycles allowed for an ack before a timeout is flagged (1..65535).
REQ-003 SHALL have parameter FatalRepeat, default 1'b1: fatal alert re-fires after each completed handshake until reset.
REQ-004 SHALL have one clock; reset is synchronous and active-high.
REQ-005 SHALL have port clk_i  input  1  clock; all state on rising edge.
REQ-006 SHALL have port rst_i  input  1  synchronous active-high reset.
REQ-007 SHALL have port err_update_i  input  NumRegs  per-register update-mismatch pulse from shadowed registers.
REQ-008 SHALL have port err_storage_i  input  NumRegs  per-register storage-mismatch level from shadowed registers.
REQ-009 SHALL have port recov_clr_i  input  NumRegs  software write-1-to-clear of recoverable status bits.
REQ-010 SHALL have port recov_ack_i  input  1  ack for the recoverable alert.
REQ-011 SHALL have port fatal_ack_i  input  1  ack for the fatal alert.
REQ-012 SHALL have port recov_req_o  output  1  recoverable alert request.
REQ-013 SHALL have port fatal_req_o  output  1  fatal alert request.
REQ-014 SHALL have port recov_status_o  output  NumRegs  sticky update-error flags.
REQ-015 SHALL have port fatal_status_o  output  NumRegs  sticky storage-error flags, cleared only by reset.
REQ-016 SHALL have port ack_timeout_o  output  2  sticky timeout flags, bit0 recoverable, bit1 fatal.

Function
REQ-017 SHALL set recov_status_o[i] on the cycle after err_update_i[i]=1; set dominates a simultaneous recov_clr_i[i].
REQ-018 SHALL set fatal_status_o[i] on the cycle after err_storage_i[i]=1; the bit is never cleared by software.
REQ-019 SHALL set an internal recov_pending flag when any err_update_i bit is 1, and clear it when the recoverable FSM enters REQ; a new event in that same cycle re-sets it.
REQ-020 SHALL set an internal fatal_pending flag when any err_storage_i bit is 1; when FatalRepeat=1 the flag stays set until reset.
REQ-021 SHALL run each alert channel through a FSM with states IDLE, REQ, WAIT_LOW.
REQ-022 SHALL move the FSM IDLE->REQ when pending=1 and ack=0; req_o is registered and equals 1 exactly in REQ.
REQ-023 SHALL move the FSM REQ->WAIT_LOW on the first cycle ack=1 is sampled.
REQ-024 SHALL move the FSM WAIT_LOW->IDLE when ack=0; a back-to-back event therefore gives req low for at least 2 cycles.
REQ-025 SHALL reset a per-channel 16-bit timeout counter on entry to REQ and increment it each REQ cycle, saturating.
REQ-026 SHALL set ack_timeout_o[ch] when the counter reaches AckTimeout; req stays asserted and the flag is sticky until reset.
REQ-027 SHALL hold the FSM in IDLE, with no spurious request, if ack is 1 while in IDLE.
REQ-028 SHALL operate the recoverable and fatal channels fully independently; simultaneous events on both fire both requests in the same cycle.

Reset
REQ-029 SHALL, while rst_i=1, drive all outputs to 0, set both FSMs to IDLE, and clear pending flags, counters and status.
REQ-030 SHALL treat rst_i asserted mid-handshake as an abort: req_o=0 on the cycle after reset, with no pending event retained.

Structure
REQ-031 SHALL place the FSM state enum (alert_hs_e: IDLE, REQ, WAIT_LOW) and the timeout counter width constant in package shadow_err_pkg.
REQ-032 SHALL implement one handshake channel (FSM plus timeout counter) as sub-module shadow_alert_hs, instantiated twice.

Verification
REQ-033 SHALL cover: err_update_i=4'b0010 pulse, ack after 3 cycles -> recov_status_o=4'b0010, recov_req_o high 1 cycle after the event and low 1 cycle after ack.
REQ-034 SHALL cover: err_storage_i[3]=1 once with FatalRepeat=1, ack each handshake -> fatal_req_o re-asserts after every ack-low, and fatal_status_o=4'b1000 persists.
REQ-035 SHALL cover: recov_clr_i[1]=1 and err_update_i[1]=1 in the same cycle -> recov_status_o[1] remains 1.
REQ-036 SHALL cover: no ack with AckTimeout=10 -> ack_timeout_o[0]=1 exactly 10 cycles after req rises, and req stays high.
REQ-037 SHALL cover: rst_i asserted while in REQ -> req low, status 0 and FSM IDLE next cycle, with no request after reset release.
REQ-038 SHALL cover: a second err_update_i during WAIT_LOW -> exactly one further handshake after ack falls.

Source files
------------

// File: rtl/shadow_err_pkg.sv
// Shared types and constants for the shadow-register error alert block.
package shadow_err_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_LOW = 2'd2
  } alert_hs_e;

  localparam int TimeoutCntW = 16;

endpackage

// File: rtl/shadow_alert_hs.sv
// One alert handshake channel: req/ack FSM plus saturating ack-timeout counter.
module shadow_alert_hs
  import shadow_err_pkg::*;
#(
  parameter int AckTimeout = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pending_i,
  input  logic ack_i,
  output logic req_o,
  output logic enter_req_o,
  output logic timeout_o
);

  localparam logic [TimeoutCntW-1:0] Limit = TimeoutCntW'(AckTimeout);

  alert_hs_e                r_state;
  alert_hs_e                w_state_next;
  logic                     r_req;
  logic                     r_timeout;
  logic [TimeoutCntW-1:0]   r_cnt;
  logic [TimeoutCntW-1:0]   w_cnt_inc;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:     if (pending_i && !ack_i) w_state_next = REQ;
      REQ:      if (ack_i)               w_state_next = WAIT_LOW;
      WAIT_LOW: if (!ack_i)              w_state_next = IDLE;
      default:                           w_state_next = IDLE;
    endcase
  end

  assign enter_req_o = (r_state == IDLE) && (w_state_next == REQ);
  assign w_cnt_inc   = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;

  // Flag is raised on the edge the count becomes AckTimeout, so it is visible
  // exactly AckTimeout cycles after req rises.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= IDLE;
      r_req     <= 1'b0;
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_req   <= (w_state_next == REQ);
      if (enter_req_o) begin
        r_cnt <= '0;
      end else if (r_state == REQ) begin
        r_cnt <= w_cnt_inc;
        if (w_cnt_inc == Limit) r_timeout <= 1'b1;
      end
    end
  end

  assign req_o     = r_req;
  assign timeout_o = r_timeout;

endmodule

// File: rtl/shadow_err_alert.sv
// Collects shadow-register mismatch errors into sticky status and drives a
// recoverable and a fatal alert handshake channel.
module shadow_err_alert
  import shadow_err_pkg::*;
#(
  parameter int NumRegs     = 4,
  parameter int AckTimeout  = 255,
  parameter bit FatalRepeat = 1'b1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NumRegs-1:0] err_update_i,
  input  logic [NumRegs-1:0] err_storage_i,
  input  logic [NumRegs-1:0] recov_clr_i,
  input  logic               recov_ack_i,
  input  logic               fatal_ack_i,
  output logic               recov_req_o,
  output logic               fatal_req_o,
  output logic [NumRegs-1:0] recov_status_o,
  output logic [NumRegs-1:0] fatal_status_o,
  output logic [1:0]         ack_timeout_o
);

  logic [NumRegs-1:0] r_recov_status;
  logic [NumRegs-1:0] r_fatal_status;
  logic               r_recov_pend;
  logic               r_fatal_pend;
  logic               w_recov_pend;
  logic               w_fatal_pend;
  logic               w_recov_enter;
  logic               w_fatal_enter;
  logic               w_recov_tmo;
  logic               w_fatal_tmo;

  // The event seen in the cycle the FSM leaves IDLE is the one that request
  // serves, so entry clears the flag; later events re-arm it.
  assign w_recov_pend = r_recov_pend | (|err_update_i);
  assign w_fatal_pend = r_fatal_pend | (|err_storage_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_recov_status <= '0;
      r_fatal_status <= '0;
      r_recov_pend   <= 1'b0;
      r_fatal_pend   <= 1'b0;
    end else begin
      r_recov_status <= (r_recov_status & ~recov_clr_i) | err_update_i;
      r_fatal_status <= r_fatal_status | err_storage_i;
      r_recov_pend   <= w_recov_pend & ~w_recov_enter;
      r_fatal_pend   <= FatalRepeat ? w_fatal_pend : (w_fatal_pend & ~w_fatal_enter);
    end
  end

  shadow_alert_hs #(
    .AckTimeout (AckTimeout)
  ) u_recov_hs (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .pending_i   (w_recov_pend),
    .ack_i       (recov_ack_i),
    .req_o       (recov_req_o),
    .enter_req_o (w_recov_enter),
    .timeout_o   (w_recov_tmo)
  );

  shadow_alert_hs #(
    .AckTimeout (AckTimeout)
  ) u_fatal_hs (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .pending_i   (w_fatal_pend),
    .ack_i       (fatal_ack_i),
    .req_o       (fatal_req_o),
    .enter_req_o (w_fatal_enter),
    .timeout_o   (w_fatal_tmo)
  );

  assign recov_status_o = r_recov_status;
  assign fatal_status_o = r_fatal_status;
  assign ack_timeout_o  = {w_fatal_tmo, w_recov_tmo};

endmodule

// File: tb/tb_shadow_err_alert.sv
// Directed bench for shadow_err_alert (NumRegs=4, AckTimeout=10, FatalRepeat=1).
module tb_shadow_err_alert;

  logic       clk = 1'b0;
  logic       rst_i;
  logic [3:0] err_update_i;
  logic [3:0] err_storage_i;
  logic [3:0] recov_clr_i;
  logic       recov_ack_i;
  logic       fatal_ack_i;
  logic       recov_req_o;
  logic       fatal_req_o;
  logic [3:0] recov_status_o;
  logic [3:0] fatal_status_o;
  logic [1:0] ack_timeout_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  shadow_err_alert #(
    .NumRegs     (4),
    .AckTimeout  (10),
    .FatalRepeat (1'b1)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .err_update_i   (err_update_i),
    .err_storage_i  (err_storage_i),
    .recov_clr_i    (recov_clr_i),
    .recov_ack_i    (recov_ack_i),
    .fatal_ack_i    (fatal_ack_i),
    .recov_req_o    (recov_req_o),
    .fatal_req_o    (fatal_req_o),
    .recov_status_o (recov_status_o),
    .fatal_status_o (fatal_status_o),
    .ack_timeout_o  (ack_timeout_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1; err_update_i = '0; err_storage_i = '0; recov_clr_i = '0;
    recov_ack_i = 1'b0; fatal_ack_i = 1'b0;
    tick(); tick();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({recov_req_o, fatal_req_o, recov_status_o, fatal_status_o, ack_timeout_o} !== 12'h000) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h want %h",
               {recov_req_o, fatal_req_o, recov_status_o, fatal_status_o, ack_timeout_o}, 12'h000);
    end
    recov_ack_i = 1'b1; fatal_ack_i = 1'b1;
    tick(); tick(); tick();
    n_cmp++;
    if ({recov_req_o, fatal_req_o} !== 2'b00) begin
      n_bad++; $display("FAIL idle_ack_no_req: got %b want %b", {recov_req_o, fatal_req_o}, 2'b00);
    end
    recov_ack_i = 1'b0; fatal_ack_i = 1'b0;
    tick();
  endtask

  task automatic test_recov_basic();
    do_reset();
    err_update_i = 4'b0010;
    tick();
    err_update_i = '0;
    n_cmp++;
    if (recov_status_o !== 4'b0010) begin
      n_bad++; $display("FAIL recov_status: got %b want %b", recov_status_o, 4'b0010);
    end
    n_cmp++;
    if (recov_req_o !== 1'b1) begin
      n_bad++; $display("FAIL recov_req_rise: got %b want %b", recov_req_o, 1'b1);
    end
    tick(); tick();
    recov_ack_i = 1'b1;
    tick();
    n_cmp++;
    if (recov_req_o !== 1'b0) begin
      n_bad++; $display("FAIL recov_req_fall: got %b want %b", recov_req_o, 1'b0);
    end
    recov_ack_i = 1'b0;
    tick(); tick(); tick();
    n_cmp++;
    if ({recov_req_o, fatal_req_o, ack_timeout_o} !== 4'b0000) begin
      n_bad++; $display("FAIL recov_after_hs: got %b want %b", {recov_req_o, fatal_req_o, ack_timeout_o}, 4'b0000);
    end
    recov_clr_i = 4'b0010;
    tick();
    recov_clr_i = '0;
    n_cmp++;
    if (recov_status_o !== 4'b0000) begin
      n_bad++; $display("FAIL recov_clr: got %b want %b", recov_status_o, 4'b0000);
    end
  endtask

  task automatic test_set_over_clear();
    do_reset();
    err_update_i = 4'b0110; tick();
    err_update_i = 4'b0010; recov_clr_i = 4'b0110; tick();
    err_update_i = '0; recov_clr_i = '0;
    n_cmp++;
    if (recov_status_o !== 4'b0010) begin
      n_bad++; $display("FAIL set_dominates_clr: got %b want %b", recov_status_o, 4'b0010);
    end
  endtask

  task automatic test_fatal_repeat();
    do_reset();
    err_storage_i = 4'b1000;
    tick();
    err_storage_i = '0;
    n_cmp++;
    if (fatal_req_o !== 1'b1) begin
      n_bad++; $display("FAIL fatal_req_rise: got %b want %b", fatal_req_o, 1'b1);
    end
    for (int h = 0; h < 3; h++) begin
      fatal_ack_i = 1'b1; tick();
      fatal_ack_i = 1'b0; tick();
      n_cmp++;
      if (fatal_req_o !== 1'b0) begin
        n_bad++; $display("FAIL fatal_gap_%0d: got %b want %b", h, fatal_req_o, 1'b0);
      end
      tick();
      n_cmp++;
      if (fatal_req_o !== 1'b1) begin
        n_bad++; $display("FAIL fatal_refire_%0d: got %b want %b", h, fatal_req_o, 1'b1);
      end
    end
    n_cmp++;
    if ({fatal_status_o, recov_req_o, recov_status_o} !== 9'b1000_0_0000) begin
      n_bad++; $display("FAIL fatal_status_persist: got %b want %b",
                        {fatal_status_o, recov_req_o, recov_status_o}, 9'b1000_0_0000);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    err_update_i = 4'b0001; err_storage_i = 4'b0100;
    tick();
    err_update_i = '0; err_storage_i = '0;
    n_cmp++;
    if ({recov_req_o, fatal_req_o} !== 2'b11) begin
      n_bad++; $display("FAIL both_req: got %b want %b", {recov_req_o, fatal_req_o}, 2'b11);
    end
    recov_ack_i = 1'b1; tick();
    n_cmp++;
    if ({recov_req_o, fatal_req_o} !== 2'b01) begin
      n_bad++; $display("FAIL independent_ack: got %b want %b", {recov_req_o, fatal_req_o}, 2'b01);
    end
    recov_ack_i = 1'b0; tick();
  endtask

  task automatic test_timeout();
    do_reset();
    err_update_i = 4'b0001;
    tick();
    err_update_i = '0;
    for (int k = 1; k <= 9; k++) begin
      tick();
      n_cmp++;
      if (ack_timeout_o !== 2'b00) begin
        n_bad++; $display("FAIL timeout_early_%0d: got %b want %b", k, ack_timeout_o, 2'b00);
      end
    end
    tick();
    n_cmp++;
    if ({ack_timeout_o, recov_req_o} !== 3'b011) begin
      n_bad++; $display("FAIL timeout_at_10: got %b want %b", {ack_timeout_o, recov_req_o}, 3'b011);
    end
    tick(); tick();
    recov_ack_i = 1'b1; tick();
    recov_ack_i = 1'b0; tick();
    n_cmp++;
    if ({ack_timeout_o, recov_req_o} !== 3'b010) begin
      n_bad++; $display("FAIL timeout_sticky: got %b want %b", {ack_timeout_o, recov_req_o}, 3'b010);
    end
  endtask

  task automatic test_reset_in_req();
    do_reset();
    err_update_i = 4'b0010; err_storage_i = 4'b0001;
    tick();
    err_storage_i = '0;
    rst_i = 1'b1;
    tick();
    err_update_i = '0;
    n_cmp++;
    if ({recov_req_o, fatal_req_o, recov_status_o, fatal_status_o, ack_timeout_o} !== 12'h000) begin
      n_bad++; $display("FAIL reset_abort: got %h want %h",
                        {recov_req_o, fatal_req_o, recov_status_o, fatal_status_o, ack_timeout_o}, 12'h000);
    end
    rst_i = 1'b0;
    tick(); tick(); tick();
    n_cmp++;
    if ({recov_req_o, fatal_req_o} !== 2'b00) begin
      n_bad++; $display("FAIL no_req_after_reset: got %b want %b", {recov_req_o, fatal_req_o}, 2'b00);
    end
  endtask

  task automatic test_back_to_back();
    int rises;
    logic prev;
    do_reset();
    err_update_i = 4'b0001; tick();
    err_update_i = '0;
    recov_ack_i = 1'b1; tick();
    err_update_i = 4'b0100; tick();
    err_update_i = '0;
    recov_ack_i = 1'b0; tick();
    n_cmp++;
    if (recov_req_o !== 1'b0) begin
      n_bad++; $display("FAIL b2b_gap: got %b want %b", recov_req_o, 1'b0);
    end
    tick();
    n_cmp++;
    if (recov_req_o !== 1'b1) begin
      n_bad++; $display("FAIL b2b_second_req: got %b want %b", recov_req_o, 1'b1);
    end
    recov_ack_i = 1'b1; tick();
    recov_ack_i = 1'b0;
    rises = 0; prev = recov_req_o;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (recov_req_o && !prev) rises++;
      prev = recov_req_o;
    end
    n_cmp++;
    if (rises !== 0 || recov_req_o !== 1'b0) begin
      n_bad++; $display("FAIL b2b_extra_hs: got rises=%0d req=%b want rises=0 req=0", rises, recov_req_o);
    end
  endtask

  initial begin
    test_reset();
    test_recov_basic();
    test_set_over_clear();
    test_fatal_repeat();
    test_simultaneous();
    test_timeout();
    test_reset_in_req();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
